// File: rtl/uart_tx_driver.sv
// uart_tx_driver: 8N1 LSB-first UART transmitter fed through a valid/ready byte FIFO
// Ports: clk, rst (synchronous, active-high)
//        in_data/in_valid/in_ready  byte push handshake into the FIFO
//        tx          serial line, idle high, registered
//        busy        frame in progress or bytes still queued, registered
//        fifo_count  bytes currently queued, 0..FIFO_DEPTH
module uart_tx_driver #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 6250000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CPB = CLK_FREQ / BAUD_RATE;
    localparam int CW  = $clog2(CPB) + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int NW  = AW + 1;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    shift;
    logic [2:0]    bit_idx;
    logic [CW-1:0] clk_cnt;
    logic          last, push, pop, to_idle;
    logic [NW-1:0] count_n;
    // Readiness ignores a same-cycle pop, so a full FIFO never accepts
    assign in_ready = !rst && (fifo_count < NW'(FIFO_DEPTH));
    always_comb begin
        last    = clk_cnt == CW'(CPB - 1);
        push    = in_valid && in_ready;
        pop     = fifo_count != '0 && (state == IDLE || (state == STOP && last));
        to_idle = !pop && (state == IDLE || (state == STOP && last));
        count_n = fifo_count + NW'(push) - NW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_n;
            busy       <= !to_idle || count_n != '0;
            clk_cnt    <= (state == IDLE || last) ? '0 : clk_cnt + 1'b1;
            case (state)
                IDLE: if (pop) begin
                    shift <= mem[rd_ptr];
                    tx    <= 1'b0;
                    state <= START;
                end
                START: if (last) begin
                    tx      <= shift[0];
                    shift   <= shift >> 1;
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (last) begin
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: if (last) begin
                    // Queued byte starts its start bit with no idle gap
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        state <= START;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_driver.sv
// tb_uart_tx_driver: directed self-checking bench for uart_tx_driver with a line decoder
module tb_uart_tx_driver;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, tx, busy;
    logic [2:0] fifo_count;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, s_tx, s_busy;
    logic [2:0] s_count;
    int errors = 0;
    int checks = 0;
    logic [7:0] got [$];
    int  mon_t = 0;
    bit  mon_on = 1'b0;
    int  mon_ferr = 0;
    logic [7:0] mon_b = 8'h00;

    always #5 clk = ~clk;

    uart_tx_driver dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx_driver #(.CLK_FREQ(100000000), .BAUD_RATE(115200), .FIFO_DEPTH(4)) u_slow (
        .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid),
        .in_ready(s_ready), .tx(s_tx), .busy(s_busy), .fifo_count(s_count)
    );

    // Line decoder for the 16-clock line: samples mid-bit on falling clock edges
    always @(negedge clk) begin
        if (rst) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (tx === 1'b0) begin
                mon_on = 1'b1;
                mon_t = 0;
            end
        end else begin
            mon_t++;
            if (mon_t == 152) begin
                if (tx !== 1'b1) mon_ferr++;
                got.push_back(mon_b);
                mon_on = 1'b0;
            end else if (mon_t >= 24 && (mon_t - 8) % 16 == 0) begin
                mon_b[(mon_t - 8) / 16 - 1] = tx;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            tick;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
    endtask

    // Walks one frame from its first start-bit cycle, counting cycles off the expected level
    task automatic scan(input bit slow, input logic [7:0] b, input int cpb, output int bad);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            for (int j = 0; j < cpb; j++) begin
                if ((slow ? s_tx : tx) !== f[c]) bad++;
                tick;
            end
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
        tick;
    endtask

    task automatic test_single;
        int bad;
        got.delete();
        push(8'h55);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_k: got %b want 1", tx); end
        tick;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start: got %b want 0", tx); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        scan(1'b0, 8'h55, 16, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_cells: %0d bad cycles want 0", bad); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
        checks++; if (got.size() !== 1 || got[0] !== 8'h55) begin errors++; $display("FAIL single_mon: got %0d bytes first %h want 55", got.size(), got.size() > 0 ? got[0] : 8'hxx); end
    endtask

    task automatic test_back_to_back;
        int n;
        logic [7:0] exp [3];
        exp = '{8'hA3, 8'h00, 8'hFF};
        got.delete();
        for (int i = 0; i < 3; i++) push(exp[i]);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL burst_peak: got %0d want 2", fifo_count); end
        wait_idle(2000, n);
        checks++; if (n !== 479) begin errors++; $display("FAIL burst_len: got %0d want 479", n); end
        checks++; if (got.size() !== 3) begin errors++; $display("FAIL burst_num: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL burst_byte%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_overfill;
        int n;
        logic [7:0] exp [6];
        exp = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
        got.delete();
        for (int i = 0; i < 5; i++) push(exp[i]);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", fifo_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
        in_data = exp[5];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 400) begin
            tick;
            n++;
        end
        checks++; if (n !== 157) begin errors++; $display("FAIL full_wait: got %0d want 157", n); end
        tick;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL refill_count: got %0d want 4", fifo_count); end
        wait_idle(2000, n);
        checks++; if (got.size() !== 6) begin errors++; $display("FAIL full_num: got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL full_byte%0d: got %h want %h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        got.delete();
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL mid_queued: got %0d want 2", fifo_count); end
        repeat (69) tick;
        rst = 1'b1;
        tick;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", tx); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick;
        got.delete();
        push(8'h81);
        tick;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL post_start: got %b want 0", tx); end
        scan(1'b0, 8'h81, 16, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL post_cells: %0d bad cycles want 0", bad); end
        checks++; if (got.size() !== 1 || got[0] !== 8'h81) begin errors++; $display("FAIL post_mon: got %0d bytes want one 81", got.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_busy: got %b want 0", busy); end
    endtask

    task automatic test_wrap;
        int n;
        int bad = 0;
        got.delete();
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) tick;
            push(8'(i));
        end
        wait_idle(5000, n);
        checks++; if (got.size() !== 20) begin errors++; $display("FAIL wrap_num: got %0d want 20", got.size()); end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_order: %0d bytes out of place want 0", bad); end
    endtask

    task automatic test_slow_baud;
        int bad;
        int n = 0;
        s_data = 8'h0D;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            tick;
            n++;
        end
        tick;
        s_valid = 1'b0;
        checks++; if (s_count !== 3'd1) begin errors++; $display("FAIL slow_count: got %0d want 1", s_count); end
        tick;
        checks++; if (s_tx !== 1'b0) begin errors++; $display("FAIL slow_start: got %b want 0", s_tx); end
        scan(1'b1, 8'h0D, 868, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL slow_cells: %0d bad cycles want 0", bad); end
        checks++; if (s_busy !== 1'b0 || s_tx !== 1'b1) begin errors++; $display("FAIL slow_end: busy=%b tx=%b want 0/1", s_busy, s_tx); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overfill;
        test_reset_mid;
        test_wrap;
        test_slow_baud;
        checks++; if (mon_ferr !== 0) begin errors++; $display("FAIL framing: %0d bad stop bits want 0", mon_ferr); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
